// File: rtl/rs232out_tx.sv
// 8N1 serial transmitter with a one-byte holding register in front of the shift register.
// Line idles high; each bit lasts DIV = CLK_HZ/BAUD clock cycles, LSB first.
module rs232out_tx #(
    parameter int unsigned CLK_HZ = 25_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rs232out_d,
    input  logic       rs232out_w,
    output logic       rs232out_busy,
    output logic       serial_out
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shifter_q;
    logic [7:0]    hold_q;
    logic          hold_valid_q;
    logic          serial_q;

    assign rs232out_busy = hold_valid_q;
    assign serial_out    = serial_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shifter_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            serial_q     <= 1'b1;
        end else begin
            // Loading only happens while the holding register is empty, and the
            // transfer to the shifter only while it is full, so the two never collide.
            if (rs232out_w && !hold_valid_q) begin
                hold_q       <= rs232out_d;
                hold_valid_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    serial_q <= 1'b1;
                    if (hold_valid_q) begin
                        shifter_q    <= hold_q;
                        hold_valid_q <= 1'b0;
                        serial_q     <= 1'b0;
                        cnt_q        <= CNT_MAX;
                        state_q      <= START;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        serial_q <= shifter_q[0];
                        idx_q    <= '0;
                        cnt_q    <= CNT_MAX;
                        state_q  <= DATA;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q <= CNT_MAX;
                        if (idx_q == 3'd7) begin
                            serial_q <= 1'b1;
                            state_q  <= STOP;
                        end else begin
                            shifter_q <= shifter_q >> 1;
                            serial_q  <= shifter_q[1];
                            idx_q     <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == '0) begin
                        // Pending byte starts right after the stop bit, no idle gap.
                        if (hold_valid_q) begin
                            shifter_q    <= hold_q;
                            hold_valid_q <= 1'b0;
                            serial_q     <= 1'b0;
                            cnt_q        <= CNT_MAX;
                            state_q      <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
